// File: rtl/spi_fl_seq_if.sv
// Request/response handshake between CPU-side logic and the spi_fl_seq command sequencer.
interface spi_fl_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_command;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic [2:0]  req_commtype;
  logic [6:0]  req_nmiso;
  logic [3:0]  req_dummy;
  logic [7:0]  req_frame;
  logic        req_wren;
  logic        req_poll;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_status;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_command, req_address, req_data, req_commtype,
           req_nmiso, req_dummy, req_frame, req_wren, req_poll, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout
  );

  modport slave (
    input  req_valid, req_command, req_address, req_data, req_commtype,
           req_nmiso, req_dummy, req_frame, req_wren, req_poll, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout
  );
endinterface

// File: rtl/spi_fl_seq.sv
// Flash command sequencer: optional WREN prefix, main command, optional WIP status polling.
// Define SPI_FL_SEQ_TIMEOUT_EN to end polling with rsp_timeout after POLL_MAX status reads.
module spi_fl_seq #(
  parameter logic [7:0]  WREN_CMD = 8'h06,
  parameter logic [7:0]  RDSR_CMD = 8'h05,
  parameter int unsigned WIP_BIT  = 0,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic         clk,
  input  logic         rst,
  spi_fl_seq_if.slave  bus,
  output logic [31:0]  m_data_in,
  output logic [31:0]  m_address,
  output logic [7:0]   m_command,
  output logic [2:0]   m_commtype,
  output logic [6:0]   m_nmiso_bits,
  output logic [3:0]   m_dummy_cycles,
  output logic [7:0]   m_frame_struct,
  output logic         m_validflag,
  input  logic         m_tready,
  input  logic [31:0]  m_data_out
);

`ifdef SPI_FL_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, WREN_ISS, WREN_WAIT, MAIN_ISS, MAIN_WAIT, POLL_ISS, POLL_WAIT, RESP
  } state_t;

  typedef struct packed {
    logic [7:0]  command;
    logic [2:0]  commtype;
    logic [6:0]  nmiso;
    logic [3:0]  dummy;
    logic [7:0]  frame;
    logic [31:0] address;
    logic [31:0] data;
  } fields_t;

  localparam fields_t WREN_FIELDS = '{command: WREN_CMD, commtype: 3'b000, nmiso: 7'd0,
                                      dummy: 4'd0, frame: 8'd0, address: 32'd0, data: 32'd0};
  localparam fields_t POLL_FIELDS = '{command: RDSR_CMD, commtype: 3'b001, nmiso: 7'd8,
                                      dummy: 4'd0, frame: 8'd0, address: 32'd0, data: 32'd0};

  state_t      state;
  fields_t     req_fields;
  fields_t     main_q;
  fields_t     m_fields;
  logic        poll_q;
  logic [15:0] poll_cnt;
  logic [15:0] poll_next;
  logic [7:0]  status_in;
  logic        wip;

  assign req_fields = '{command: bus.req_command, commtype: bus.req_commtype,
                        nmiso: bus.req_nmiso, dummy: bus.req_dummy, frame: bus.req_frame,
                        address: bus.req_address, data: bus.req_data};

  assign m_command      = m_fields.command;
  assign m_commtype     = m_fields.commtype;
  assign m_nmiso_bits   = m_fields.nmiso;
  assign m_dummy_cycles = m_fields.dummy;
  assign m_frame_struct = m_fields.frame;
  assign m_address      = m_fields.address;
  assign m_data_in      = m_fields.data;

  // Counter saturates so a stuck device can never make it wrap back to zero
  assign poll_next = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign status_in = m_data_out[7:0];
  assign wip       = status_in[WIP_BIT];

  // The master's tready falling marks acceptance of an issue; rising again marks completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= 32'd0;
      bus.rsp_status  <= 8'd0;
      bus.rsp_timeout <= 1'b0;
      m_validflag     <= 1'b0;
      m_fields        <= '0;
      main_q          <= '0;
      poll_q          <= 1'b0;
      poll_cnt        <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            main_q          <= req_fields;
            poll_q          <= bus.req_poll;
            poll_cnt        <= 16'd0;
            bus.rsp_status  <= 8'd0;
            bus.rsp_timeout <= 1'b0;
            bus.req_ready   <= 1'b0;
            m_validflag     <= 1'b1;
            if (bus.req_wren) begin
              m_fields <= WREN_FIELDS;
              state    <= WREN_ISS;
            end else begin
              m_fields <= req_fields;
              state    <= MAIN_ISS;
            end
          end
        end
        WREN_ISS: begin
          if (!m_tready) begin
            m_validflag <= 1'b0;
            state       <= WREN_WAIT;
          end
        end
        MAIN_ISS: begin
          if (!m_tready) begin
            m_validflag <= 1'b0;
            state       <= MAIN_WAIT;
          end
        end
        POLL_ISS: begin
          if (!m_tready) begin
            m_validflag <= 1'b0;
            state       <= POLL_WAIT;
          end
        end
        WREN_WAIT: begin
          if (m_tready) begin
            m_fields    <= main_q;
            m_validflag <= 1'b1;
            state       <= MAIN_ISS;
          end
        end
        MAIN_WAIT: begin
          if (m_tready) begin
            bus.rsp_data <= m_data_out;
            if (poll_q) begin
              m_fields    <= POLL_FIELDS;
              m_validflag <= 1'b1;
              state       <= POLL_ISS;
            end else begin
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        POLL_WAIT: begin
          if (m_tready) begin
            bus.rsp_status <= status_in;
            poll_cnt       <= poll_next;
            if (!wip) begin
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else if (TIMEOUT_EN && (poll_next == POLL_MAX)) begin
              bus.rsp_timeout <= 1'b1;
              bus.rsp_valid   <= 1'b1;
              state           <= RESP;
            end else begin
              m_validflag <= 1'b1;
              state       <= POLL_ISS;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_fl_seq.sv
// Scoreboard bench for spi_fl_seq: behavioural SPI master model, request driver, response monitor.
module tb_spi_fl_seq;
  localparam logic [7:0] WREN_CMD = 8'h06;
  localparam logic [7:0] RDSR_CMD = 8'h05;
  localparam int         WIP_BIT  = 0;
  localparam int         POLL_MAX = 4;
`ifdef SPI_FL_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  command;
    logic [2:0]  commtype;
    logic [6:0]  nmiso;
    logic [3:0]  dummy;
    logic [7:0]  frame;
    logic [31:0] address;
    logic [31:0] data;
  } xfer_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  status;
    logic        timeout;
  } rsp_t;

  localparam xfer_t WREN_X = '{WREN_CMD, 3'b000, 7'd0, 4'd0, 8'd0, 32'd0, 32'd0};
  localparam xfer_t POLL_X = '{RDSR_CMD, 3'b001, 7'd8, 4'd0, 8'd0, 32'd0, 32'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_data_in, m_address, m_data_out;
  logic [7:0]  m_command, m_frame_struct;
  logic [2:0]  m_commtype;
  logic [6:0]  m_nmiso_bits;
  logic [3:0]  m_dummy_cycles;
  logic        m_validflag, m_tready;

  always #5 clk = ~clk;

  spi_fl_seq_if bus();

  spi_fl_seq #(.WREN_CMD(WREN_CMD), .RDSR_CMD(RDSR_CMD), .WIP_BIT(WIP_BIT), .POLL_MAX(16'd4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .m_data_in(m_data_in), .m_address(m_address), .m_command(m_command),
    .m_commtype(m_commtype), .m_nmiso_bits(m_nmiso_bits), .m_dummy_cycles(m_dummy_cycles),
    .m_frame_struct(m_frame_struct), .m_validflag(m_validflag), .m_tready(m_tready),
    .m_data_out(m_data_out)
  );

  xfer_t       exp_xfer_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] ret_data_q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          mst = 0;
  int          force_hold = -1;
  int          force_busy = -1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic xfer_t curFields();
    return '{m_command, m_commtype, m_nmiso_bits, m_dummy_cycles, m_frame_struct, m_address, m_data_in};
  endfunction

  // Master model: tready high while idle, held for a while after validflag, then busy, then done
  initial begin
    xfer_t cur;
    int    hold_left;
    int    busy_left;
    m_tready   = 1'b1;
    m_data_out = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mst      = 0;
        m_tready = 1'b1;
      end else begin
        case (mst)
          0: if (m_validflag) begin
            cur = curFields();
            if (exp_xfer_q.size() == 0) begin
              nvec++;
              nerr++;
              $display("[TB] FAIL unexpected_xfer: got command %0h, expected no transfer", cur.command);
            end else begin
              checkOutput("xfer_fields", 128'(cur), 128'(exp_xfer_q.pop_front()));
            end
            hold_left = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
            busy_left = (force_busy >= 0) ? force_busy : int'($urandom_range(1, 3));
            if (hold_left == 0) begin
              m_tready   = 1'b0;
              m_data_out = $urandom;
              mst        = 2;
            end else begin
              mst = 1;
            end
          end
          1: begin
            checkOutput("issue_hold", 128'({m_validflag, curFields()}), 128'({1'b1, cur}));
            hold_left--;
            if (hold_left == 0) begin
              m_tready   = 1'b0;
              m_data_out = $urandom;
              mst        = 2;
            end
          end
          default: begin
            checkOutput("vflag_in_wait", 128'(m_validflag), 128'(1'b0));
            busy_left--;
            if (busy_left <= 0) begin
              m_data_out = (ret_data_q.size() != 0) ? ret_data_q.pop_front() : 32'd0;
              m_tready   = 1'b1;
              mst        = 0;
            end
          end
        endcase
      end
    end
  end

  // Response monitor: compares each newly presented response with the scoreboard head
  initial begin
    logic prev;
    rsp_t got;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.rsp_valid && !prev) begin
          got = '{bus.rsp_data, bus.rsp_status, bus.rsp_timeout};
          if (exp_rsp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL unexpected_rsp: got %0h, expected no response", got);
          end else begin
            checkOutput("rsp", 128'(got), 128'(exp_rsp_q.pop_front()));
          end
        end
        prev = bus.rsp_valid;
      end
    end
  end

  task automatic driveRequest(input xfer_t x, input bit wren, input bit poll);
    int waited;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_command  = x.command;
    bus.req_commtype = x.commtype;
    bus.req_nmiso    = x.nmiso;
    bus.req_dummy    = x.dummy;
    bus.req_frame    = x.frame;
    bus.req_address  = x.address;
    bus.req_data     = x.data;
    bus.req_wren     = wren;
    bus.req_poll     = poll;
    waited = 0;
    while (!bus.req_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("req_accept_in_time", 128'(waited < 500), 128'(1'b1));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wren  = 1'b0;
    bus.req_poll  = 1'b0;
  endtask

  // Reference model: expected transfer list, data returned per transfer, and final response
  task automatic applyStimulus(input bit wren, input bit poll, input xfer_t main_x,
                               input logic [31:0] rdata, input int nbusy, input bit fixed_st,
                               input logic [7:0] busy_val, input logic [7:0] clear_val, input int bp);
    logic [7:0]  st;
    logic [7:0]  last_st;
    logic [31:0] w;
    logic [40:0] snap;
    bit          tmo;
    int          npolls;
    int          waited;
    if (wren) begin
      exp_xfer_q.push_back(WREN_X);
      ret_data_q.push_back($urandom);
    end
    exp_xfer_q.push_back(main_x);
    ret_data_q.push_back(rdata);
    last_st = 8'd0;
    tmo     = 1'b0;
    if (poll) begin
      tmo    = TIMEOUT_EN && (nbusy >= POLL_MAX);
      npolls = tmo ? POLL_MAX : nbusy + 1;
      for (int i = 0; i < npolls; i++) begin
        if (fixed_st) begin
          st = (i < nbusy) ? busy_val : clear_val;
        end else begin
          st = 8'($urandom);
          st[WIP_BIT] = (i < nbusy);
        end
        w = $urandom;
        w[7:0] = st;
        exp_xfer_q.push_back(POLL_X);
        ret_data_q.push_back(w);
        last_st = st;
      end
    end
    exp_rsp_q.push_back('{rdata, last_st, tmo});

    driveRequest(main_x, wren, poll);
    waited = 0;
    while (!bus.rsp_valid && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rsp_in_time", 128'(waited < 1000), 128'(1'b1));
    snap = {bus.rsp_data, bus.rsp_status, bus.rsp_timeout};
    repeat (bp) begin
      @(negedge clk);
      checkOutput("rsp_backpressure",
                  128'({bus.rsp_valid, bus.req_ready, m_validflag, bus.rsp_data, bus.rsp_status, bus.rsp_timeout}),
                  128'({1'b1, 1'b0, 1'b0, snap}));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("idle_after_rsp", 128'({bus.req_ready, bus.rsp_valid}), 128'({1'b1, 1'b0}));
  endtask

  function automatic xfer_t randXfer();
    return '{8'($urandom), 3'($urandom), 7'($urandom), 4'($urandom), 8'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    xfer_t x;
    int    waited;
    bus.req_valid    = 1'b0;
    bus.req_wren     = 1'b0;
    bus.req_poll     = 1'b0;
    bus.req_command  = 8'd0;
    bus.req_commtype = 3'd0;
    bus.req_nmiso    = 7'd0;
    bus.req_dummy    = 4'd0;
    bus.req_frame    = 8'd0;
    bus.req_address  = 32'd0;
    bus.req_data     = 32'd0;
    bus.rsp_ready    = 1'b0;

    #1 rst = 1'b1;
    #1;
    checkOutput("reset_outputs",
                128'({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.rsp_timeout, m_validflag}),
                128'({1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0}));
    checkOutput("reset_fields", 128'(curFields()), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] read");
    x = '{8'h03, 3'b010, 7'd32, 4'd0, 8'd0, 32'h0000_1000, 32'd0};
    applyStimulus(1'b0, 1'b0, x, 32'hDEADBEEF, 0, 1'b0, 8'd0, 8'd0, 0);
    checkOutput("read_single_xfer", 128'(exp_xfer_q.size()), 128'(0));

    $display("[TB] program with wren and poll");
    x = '{8'h02, 3'b011, 7'd0, 4'd0, 8'd0, 32'h0002_0040, 32'hA5A5_1234};
    applyStimulus(1'b1, 1'b1, x, 32'h0BAD_F00D, 2, 1'b1, 8'h03, 8'h00, 1);

    $display("[TB] response backpressure");
    x = '{8'h0B, 3'b010, 7'd16, 4'd8, 8'h11, 32'h00FF_0000, 32'd0};
    applyStimulus(1'b0, 1'b1, x, 32'h1357_9BDF, 1, 1'b0, 8'd0, 8'd0, 10);

    $display("[TB] long tready hold");
    force_hold = 5;
    x = '{8'h03, 3'b010, 7'd32, 4'd0, 8'd0, 32'h0000_2000, 32'd0};
    applyStimulus(1'b1, 1'b0, x, 32'hCAFE_0001, 0, 1'b0, 8'd0, 8'd0, 0);
    force_hold = -1;

`ifdef SPI_FL_SEQ_TIMEOUT_EN
    $display("[TB] poll timeout");
    x = '{8'h20, 3'b001, 7'd0, 4'd0, 8'd0, 32'h0001_0000, 32'd0};
    applyStimulus(1'b1, 1'b1, x, 32'h7777_0000, 10, 1'b1, 8'h01, 8'h00, 2);
`endif

    $display("[TB] reset during main wait");
    force_busy = 30;
    x = '{8'h03, 3'b010, 7'd32, 4'd0, 8'h22, 32'h0000_3000, 32'h5555_AAAA};
    exp_xfer_q.push_back(x);
    ret_data_q.push_back(32'h1234_5678);
    driveRequest(x, 1'b0, 1'b0);
    waited = 0;
    while (mst != 2 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reached_main_wait", 128'(waited < 200), 128'(1'b1));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midop_reset_outputs",
                128'({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.rsp_timeout, m_validflag}),
                128'({1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0}));
    checkOutput("midop_reset_fields", 128'(curFields()), 128'(0));
    exp_xfer_q.delete();
    ret_data_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    force_busy = -1;
    x = '{8'h03, 3'b010, 7'd32, 4'd0, 8'd0, 32'h0000_4000, 32'd0};
    applyStimulus(1'b0, 1'b1, x, 32'h8888_9999, 1, 1'b0, 8'd0, 8'd0, 0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom), 1'($urandom), randXfer(), $urandom,
                    int'($urandom_range(0, 5)), 1'b0, 8'd0, 8'd0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    checkOutput("xfer_queue_drained", 128'(exp_xfer_q.size()), 128'(0));
    checkOutput("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'(0));
    checkOutput("ret_queue_drained", 128'(ret_data_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    nerr++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
